// File: rtl/param_spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// param_spi_ram_pkg : opcodes and arming-state type shared by the SPI RAM
// Rev 1.0
// ============================================================================
package param_spi_ram_pkg;

  localparam logic [1:0] c_OP_WR_ADDR = 2'b00;
  localparam logic [1:0] c_OP_WR_DATA = 2'b01;
  localparam logic [1:0] c_OP_RD_ADDR = 2'b10;
  localparam logic [1:0] c_OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WA   = 2'b01,
    S_RA   = 2'b10,
    S_WRA  = 2'b11
  } arm_state_t;

  function automatic arm_state_t arm_state(input logic i_wr, input logic i_rd);
    arm_state_t v_st;
    case ({i_rd, i_wr})
      2'b01:   v_st = S_WA;
      2'b10:   v_st = S_RA;
      2'b11:   v_st = S_WRA;
      default: v_st = S_IDLE;
    endcase
    return v_st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_core.sv
`default_nettype none
// ============================================================================
// spi_ram_core : word memory, one synchronous write port, one registered read
// Rev 1.0
// ============================================================================
module spi_ram_core #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // The array itself carries no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/param_spi_ram.sv
`default_nettype none
// ============================================================================
// param_spi_ram : command-driven RAM with armed write/read address registers.
// Optional PARAM_SPI_RAM_AUTOINC_EN: post-increment addresses on data commands.
// Rev 1.0
// ============================================================================
module param_spi_ram
  import param_spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              err
);

  localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  arm_state_t        r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_tx_valid;
  logic              r_err;

  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_data;
  logic [ADDR_W-1:0] w_addr;
  logic              w_addr_ok;
  logic              w_wr_armed;
  logic              w_rd_armed;
  logic              w_we;
  logic              w_re;

  assign w_op       = din[DATA_W+1:DATA_W];
  assign w_data     = din[DATA_W-1:0];
  assign w_addr     = din[ADDR_W-1:0];
  assign w_addr_ok  = ({1'b0, w_addr} < c_DEPTH_EXT);
  assign w_wr_armed = (r_state == S_WA) || (r_state == S_WRA);
  assign w_rd_armed = (r_state == S_RA) || (r_state == S_WRA);

  // Commands arriving while reset is asserted must not touch the memory.
  assign w_we = rst_n && rx_valid && (w_op == c_OP_WR_DATA) && w_wr_armed;
  assign w_re = rst_n && rx_valid && (w_op == c_OP_RD_DATA) && w_rd_armed;

`ifdef PARAM_SPI_RAM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(MEM_DEPTH - 1);

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] i_addr);
    return (i_addr == c_LAST) ? '0 : i_addr + ADDR_W'(1);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (rx_valid) begin
        case (w_op)
          c_OP_WR_ADDR: begin
            r_state <= arm_state(w_addr_ok, w_rd_armed);
            if (w_addr_ok) r_wr_addr <= w_addr;
            else           r_err     <= 1'b1;
          end
          c_OP_RD_ADDR: begin
            r_state <= arm_state(w_wr_armed, w_addr_ok);
            if (w_addr_ok) r_rd_addr <= w_addr;
            else           r_err     <= 1'b1;
          end
          c_OP_WR_DATA: begin
            if (w_wr_armed) begin
`ifdef PARAM_SPI_RAM_AUTOINC_EN
              r_wr_addr <= f_next_addr(r_wr_addr);
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          c_OP_RD_DATA: begin
            if (w_rd_armed) begin
              r_tx_valid <= 1'b1;
`ifdef PARAM_SPI_RAM_AUTOINC_EN
              r_rd_addr  <= f_next_addr(r_rd_addr);
`endif
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  spi_ram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_data),
    .i_re    (w_re),
    .i_raddr (r_rd_addr),
    .o_rdata (dout)
  );

  assign tx_valid = r_tx_valid;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_param_spi_ram.sv
`default_nettype none
// ============================================================================
// tb_param_spi_ram : scoreboard bench for param_spi_ram (MEM_DEPTH = 200)
// Rev 1.0
// ============================================================================
module tb_param_spi_ram;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW+1:0] din      = '0;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          err;

  param_spi_ram #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit            known;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       exp_q[$];
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  int            m_wa = 0;
  int            m_ra = 0;
  bit            m_warm = 0;
  bit            m_rarm = 0;
  bit            m_err  = 0;
  logic [DW-1:0] m_last = '0;
  bit            m_last_known = 1;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of stimulus and advances the reference model to the
  // state the DUT should hold after the next rising edge.
  task automatic issue(input bit rst, input bit v, input logic [1:0] op, input logic [DW-1:0] pl);
    int a;
    @(posedge clk);
    #2;
    rst_n    = !rst;
    rx_valid = v;
    din      = {op, pl};
    a        = int'(pl);
    if (rst) begin
      m_err = 0; m_wa = 0; m_ra = 0; m_warm = 0; m_rarm = 0;
      m_last = '0; m_last_known = 1;
    end else if (v) begin
      case (op)
        OP_WA: if (a < DEPTH) begin m_wa = a; m_warm = 1; end
               else begin m_err = 1; m_warm = 0; end
        OP_RA: if (a < DEPTH) begin m_ra = a; m_rarm = 1; end
               else begin m_err = 1; m_rarm = 0; end
        OP_WD: if (m_warm) begin
                 m_mem[m_wa] = pl;
                 m_known[m_wa] = 1;
`ifdef PARAM_SPI_RAM_AUTOINC_EN
                 m_wa = (m_wa + 1) % DEPTH;
`endif
               end else m_err = 1;
        default: if (m_rarm) begin
                   exp_q.push_back('{m_known[m_ra], m_mem[m_ra]});
`ifdef PARAM_SPI_RAM_AUTOINC_EN
                   m_ra = (m_ra + 1) % DEPTH;
`endif
                 end else m_err = 1;
      endcase
    end
  endtask

  task automatic idle();
    issue(0, 0, OP_WA, '0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("err", 32'(err), 32'(m_err));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("tx_valid_pulse", 32'(tx_valid), 32'd1);
          if (e.known) chk("rd_dout", 32'(dout), 32'(e.data));
          m_last       = e.data;
          m_last_known = e.known;
        end else begin
          chk("tx_valid_idle", 32'(tx_valid), 32'd0);
          if (m_last_known) chk("dout_hold", 32'(dout), 32'(m_last));
        end
      end
    end
  end

  initial begin
    int r;
    logic [1:0] op;
    logic [DW-1:0] pl;

    issue(1, 0, OP_WA, '0);
    mon_en = 1;
    idle();
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_tx", 32'(tx_valid), 32'h0);
    chk("reset_err", 32'(err), 32'h0);

    // basic write/read round trip
    issue(0, 1, OP_WA, 8'h05);
    issue(0, 1, OP_WD, 8'hA5);
    issue(0, 1, OP_RA, 8'h05);
    issue(0, 1, OP_RD, 8'h00);
    idle();
    chk("rt_dout", 32'(dout), 32'hA5);
    chk("rt_tx", 32'(tx_valid), 32'h1);
    chk("rt_err", 32'(err), 32'h0);
    idle();
    chk("rt_tx_one_cycle", 32'(tx_valid), 32'h0);
    chk("rt_dout_hold", 32'(dout), 32'hA5);

    // unarmed data commands
    issue(1, 0, OP_WA, '0);
    issue(0, 1, OP_WD, 8'h11);
    issue(0, 1, OP_RD, 8'h00);
    idle();
    chk("unarmed_err", 32'(err), 32'h1);
    chk("unarmed_tx", 32'(tx_valid), 32'h0);
    chk("unarmed_dout", 32'(dout), 32'h0);

    // out-of-range read address disarms reads
    issue(1, 0, OP_WA, '0);
    issue(0, 1, OP_RA, 8'h10);
    issue(0, 1, OP_RA, 8'hC8);
    issue(0, 1, OP_RD, 8'h00);
    idle();
    chk("range_err", 32'(err), 32'h1);
    chk("range_no_tx", 32'(tx_valid), 32'h0);

    // repeated writes to one address
    issue(1, 0, OP_WA, '0);
    issue(0, 1, OP_WA, 8'h10);
    issue(0, 1, OP_WD, 8'h33);
    issue(0, 1, OP_WD, 8'h44);
    issue(0, 1, OP_RA, 8'h10);
    issue(0, 1, OP_RD, 8'h00);
    idle();
`ifdef PARAM_SPI_RAM_AUTOINC_EN
    chk("repeat_wr_dout", 32'(dout), 32'h33);
`else
    chk("repeat_wr_dout", 32'(dout), 32'h44);
`endif

    // write immediately followed by read of the same word
    issue(0, 1, OP_WA, 8'h07);
    issue(0, 1, OP_RA, 8'h07);
    issue(0, 1, OP_WD, 8'h9C);
    issue(0, 1, OP_RD, 8'h00);
    idle();
    chk("wr_then_rd", 32'(dout), 32'h9C);

    // back-to-back reads
    issue(0, 1, OP_RA, 8'h07);
    issue(0, 1, OP_RD, 8'h00);
    issue(0, 1, OP_RD, 8'h00);
    issue(0, 1, OP_RD, 8'h00);
    idle();

    // read command coinciding with reset is ignored
    issue(0, 1, OP_WA, 8'h05);
    issue(0, 1, OP_WD, 8'h77);
    issue(0, 1, OP_RA, 8'h05);
    issue(1, 1, OP_RD, 8'h00);
    idle();
    chk("rst_rd_tx", 32'(tx_valid), 32'h0);
    chk("rst_rd_dout", 32'(dout), 32'h0);
    chk("rst_rd_err", 32'(err), 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      op = 2'($urandom_range(0, 3));
      if ((op == OP_WA || op == OP_RA) && ($urandom_range(0, 9) < 7))
        pl = DW'($urandom_range(0, 15));
      else
        pl = DW'($urandom_range(0, 255));
      issue(r < 2, r >= 12, op, pl);
    end
    idle();
    idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
